shift_exec_stage: RTL and testbench

SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

---
 rtl/shift_exec_pkg.sv | 46 ++++
 rtl/shift_exec_shifter.sv | 29 ++
 rtl/shift_exec_stage.sv | 135 +++++++++++++
 tb/tb_shift_exec_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_exec_pkg.sv
// Shared definitions for the shift execute stage and the decode logic that
// feeds it: default datapath width, shift opcode constants and a small
// opcode decoder that turns an opcode into shifter controls.
package shift_exec_pkg;

    localparam int DATA_W = 32;

    // Shift opcodes; 6 and 7 are undefined.
    localparam logic [2:0] OP_SLL  = 3'd0;
    localparam logic [2:0] OP_SRL  = 3'd1;
    localparam logic [2:0] OP_SRA  = 3'd2;
    localparam logic [2:0] OP_SLLV = 3'd3;
    localparam logic [2:0] OP_SRLV = 3'd4;
    localparam logic [2:0] OP_SRAV = 3'd5;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef struct packed {
        logic legal;    // opcode is defined
        logic var_amt;  // amount comes from rs_data instead of shamt_imm
        dir_e dir;
        logic arith;    // right shift replicates the sign bit
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [2:0] op);
        op_dec_t d;
        d.legal   = 1'b1;
        d.var_amt = 1'b0;
        d.dir     = DIR_LEFT;
        d.arith   = 1'b0;
        case (op)
            OP_SLL:  ;
            OP_SRL:  d.dir = DIR_RIGHT;
            OP_SRA:  begin d.dir = DIR_RIGHT; d.arith = 1'b1; end
            OP_SLLV: d.var_amt = 1'b1;
            OP_SRLV: begin d.var_amt = 1'b1; d.dir = DIR_RIGHT; end
            OP_SRAV: begin d.var_amt = 1'b1; d.dir = DIR_RIGHT; d.arith = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/shift_exec_shifter.sv
// Combinational barrel shifter.
// Ports:
//   in             value to shift
//   shamt          shift amount, log2(DATA_W) bits (no saturation here)
//   dir            0 = left, 1 = right
//   arith_or_logic 1 = arithmetic right shift, 0 = logical
//   out            shifted value
module shift_exec_shifter #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]         in,
    input  logic [$clog2(DATA_W)-1:0] shamt,
    input  logic                      dir,
    input  logic                      arith_or_logic,
    output logic [DATA_W-1:0]         out
);

    always_comb begin
        out = '0;
        if (!dir) begin
            out = in << shamt;
        end else if (arith_or_logic) begin
            out = DATA_W'($signed(in) >>> shamt);
        end else begin
            out = in >> shamt;
        end
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-register shift execute stage.
// Stage A holds the accepted op and operands; the shifter sits between A and
// B; stage B holds the result presented downstream.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           upstream handshake
//   op, rt_data, rs_data,
//   shamt_imm, rd_in            opcode, operands, destination tag
//   out_valid/out_ready         downstream handshake
//   out_data, out_rd            result and tag
//   out_zero, out_illegal       result-is-zero, opcode-was-undefined flags
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until the
// transfer; ready may depend combinationally on the consumer's ready.
module shift_exec_stage #(
    parameter int DATA_W = shift_exec_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [4:0]        shamt_imm,
    input  logic [4:0]        rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_zero,
    output logic              out_illegal
);

    import shift_exec_pkg::*;

    localparam int SHAMT_W = $clog2(DATA_W);

    // Stage A
    logic              a_valid;
    logic [2:0]        a_op;
    logic [DATA_W-1:0] a_rt;
    logic [DATA_W-1:0] a_rs;
    logic [4:0]        a_shamt_imm;
    logic [4:0]        a_rd;

    // Stage B
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic [4:0]        b_rd;
    logic              b_illegal;

    logic              a_advance;
    op_dec_t           dec;
    logic [DATA_W-1:0] amount;
    logic              saturate;
    logic [DATA_W-1:0] sh_out;
    logic [DATA_W-1:0] result;

    // A moves into B when B is empty or is being drained this cycle.
    assign a_advance = a_valid && (!b_valid || out_ready);
    assign in_ready  = !rst && (!a_valid || a_advance);

    assign dec = decode_op(a_op);

    // The full variable amount is kept so that, e.g., rs=33 saturates instead
    // of wrapping to a shift by 1.
    always_comb begin
        amount   = dec.var_amt ? a_rs : DATA_W'(a_shamt_imm);
        saturate = (amount >= DATA_W'(DATA_W));
        result   = '0;
        if (dec.legal) begin
            if (!saturate) begin
                result = sh_out;
            end else if (dec.arith) begin
                result = {DATA_W{a_rt[DATA_W-1]}};
            end
        end
    end

    shift_exec_shifter #(
        .DATA_W(DATA_W)
    ) u_shifter (
        .in             (a_rt),
        .shamt          (amount[SHAMT_W-1:0]),
        .dir            (dec.dir),
        .arith_or_logic (dec.arith),
        .out            (sh_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid     <= 1'b0;
            a_op        <= '0;
            a_rt        <= '0;
            a_rs        <= '0;
            a_shamt_imm <= '0;
            a_rd        <= '0;
        end else if (in_valid && in_ready) begin
            a_valid     <= 1'b1;
            a_op        <= op;
            a_rt        <= rt_data;
            a_rs        <= rs_data;
            a_shamt_imm <= shamt_imm;
            a_rd        <= rd_in;
        end else if (a_advance) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid   <= 1'b0;
            b_data    <= '0;
            b_rd      <= '0;
            b_illegal <= 1'b0;
        end else if (a_advance) begin
            b_valid   <= 1'b1;
            b_data    <= result;
            b_rd      <= a_rd;
            b_illegal <= !dec.legal;
        end else if (out_ready) begin
            b_valid <= 1'b0;
        end
    end

    assign out_valid   = b_valid;
    assign out_data    = b_data;
    assign out_rd      = b_rd;
    assign out_illegal = b_illegal;
    // Derived from the registered result; gated so it reads 0 when empty.
    assign out_zero    = b_valid && (b_data == '0);

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rt_data;
    logic [31:0] rs_data;
    logic [4:0]  shamt_imm;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_zero;
    logic        out_illegal;

    shift_exec_stage #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .rt_data     (rt_data),
        .rs_data     (rs_data),
        .shamt_imm   (shamt_imm),
        .rd_in       (rd_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rt;
        logic [31:0] rs;
        logic [4:0]  sh;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rt;
        logic [31:0] rs;
        logic [4:0]  sh;
        logic [4:0]  rd;
    } sop_t;

    localparam int NV = 16;
    vec_t vecs[NV];
    sop_t sops[16];
    logic [36:0] exp_q[$];   // {rd, data}

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference behaviour of the shift ops, written from the opcode table.
    function automatic logic [31:0] model(input logic [2:0] mop, input logic [31:0] rt,
                                          input logic [31:0] rs, input logic [4:0] sh);
        logic [31:0] amt;
        logic [63:0] wide;
        amt = (mop <= 3'd2) ? {27'd0, sh} : rs;
        case (mop)
            3'd0, 3'd3: return (amt >= 32) ? 32'd0 : (rt << amt[4:0]);
            3'd1, 3'd4: return (amt >= 32) ? 32'd0 : (rt >> amt[4:0]);
            3'd2, 3'd5: begin
                if (amt >= 32) return {32{rt[31]}};
                wide = {{32{rt[31]}}, rt} >> amt[4:0];
                return wide[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive_op(input logic [2:0] o, input logic [31:0] rt, input logic [31:0] rs,
                            input logic [4:0] sh, input logic [4:0] rd);
        op = o; rt_data = rt; rs_data = rs; shamt_imm = sh; rd_in = rd;
    endtask

    // Streams n ops from sops[] with out_ready low for the first stall_cycles
    // cycles, then high (or random when rand_ready is set).
    task automatic run_stream(input int n_ops, input int stall_cycles, input bit rand_ready,
                              output int first_block, output int delivered);
        int sent = 0;
        int cycles = 0;
        bit stalled_prev = 0;
        logic [31:0] held_data = '0;
        logic [4:0]  held_rd = '0;
        logic rdy;
        logic [36:0] e;
        first_block = -1;
        delivered = 0;
        while ((sent < n_ops || delivered < n_ops) && cycles < 200) begin
            @(negedge clk);
            rdy = (cycles < stall_cycles) ? 1'b0 :
                  (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
            out_ready = rdy;
            if (sent < n_ops) begin
                in_valid = 1'b1;
                drive_op(sops[sent].op, sops[sent].rt, sops[sent].rs, sops[sent].sh, sops[sent].rd);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_data);
                check("hold_rd", out_rd, held_rd);
            end
            if (in_valid && !in_ready && first_block < 0) first_block = sent;
            stalled_prev = out_valid && !rdy;
            held_data = out_data;
            held_rd = out_rd;
            if (out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", out_data, e[31:0]);
                    check("stream_rd", out_rd, e[36:32]);
                end
                delivered++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({sops[sent].rd,
                                 model(sops[sent].op, sops[sent].rt, sops[sent].rs, sops[sent].sh)});
                sent++;
            end
            cycles++;
        end
        check("stream_delivered", delivered, n_ops);
        check("stream_queue_empty", exp_q.size(), 0);
    endtask

    int fb, dl, seen;

    initial begin
        // op, rt, rs, shamt_imm, rd, expected data, zero, illegal
        vecs[0]  = '{3'd0, 32'd1234,       32'd0,          5'd4,  5'd1,  32'd19744,    1'b0, 1'b0};
        vecs[1]  = '{3'd2, 32'h8000_0000,  32'd0,          5'd4,  5'd2,  32'hF800_0000, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 32'h8000_0000,  32'd0,          5'd4,  5'd3,  32'h0800_0000, 1'b0, 1'b0};
        vecs[3]  = '{3'd4, 32'hFFFF_FFFF,  32'd40,         5'd0,  5'd4,  32'h0000_0000, 1'b1, 1'b0};
        vecs[4]  = '{3'd5, 32'h8000_0001,  32'd33,         5'd0,  5'd5,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[5]  = '{3'd6, 32'h1234_5678,  32'd3,          5'd3,  5'd6,  32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{3'd7, 32'hFFFF_FFFF,  32'd1,          5'd1,  5'd7,  32'h0000_0000, 1'b1, 1'b1};
        vecs[7]  = '{3'd0, 32'hDEAD_BEEF,  32'd9,          5'd0,  5'd8,  32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[8]  = '{3'd3, 32'd3,          32'd31,         5'd0,  5'd9,  32'h8000_0000, 1'b0, 1'b0};
        vecs[9]  = '{3'd4, 32'hFFFF_FFFF,  32'd32,         5'd0,  5'd10, 32'h0000_0000, 1'b1, 1'b0};
        vecs[10] = '{3'd5, 32'h7FFF_FFF0,  32'h8000_0004,  5'd0,  5'd11, 32'h0000_0000, 1'b1, 1'b0};
        vecs[11] = '{3'd5, 32'h8000_0000,  32'd4,          5'd0,  5'd12, 32'hF800_0000, 1'b0, 1'b0};
        vecs[12] = '{3'd0, 32'd0,          32'd0,          5'd3,  5'd13, 32'h0000_0000, 1'b1, 1'b0};
        vecs[13] = '{3'd1, 32'h8000_0000,  32'd0,          5'd31, 5'd14, 32'h0000_0001, 1'b0, 1'b0};
        vecs[14] = '{3'd3, 32'd1,          32'd32,         5'd0,  5'd15, 32'h0000_0000, 1'b1, 1'b0};
        vecs[15] = '{3'd2, 32'h8000_0000,  32'd0,          5'd31, 5'd16, 32'hFFFF_FFFF, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_op(3'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_illegal", out_illegal, 0);

        // Table vectors; the first is offered on the first edge after reset.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            drive_op(vecs[i].op, vecs[i].rt, vecs[i].rs, vecs[i].sh, vecs[i].rd);
            #1;
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("v%0d_not_early", i), out_valid, 0);
            @(negedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), out_valid, 1);
            check($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
            check($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
            check($sformatf("v%0d_zero", i), out_zero, vecs[i].exp_zero);
            check($sformatf("v%0d_illegal", i), out_illegal, vecs[i].exp_ill);
        end

        // Stream ops for the multi-cycle sequences.
        for (int i = 0; i < 16; i++) begin
            sops[i].op = 3'($urandom_range(0, 7));
            sops[i].rt = $urandom;
            sops[i].rs = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 40));
            sops[i].sh = 5'($urandom_range(0, 31));
            sops[i].rd = 5'(i + 1);
        end

        // Four back-to-back ops, downstream stalled for 3 cycles.
        run_stream(4, 3, 1'b0, fb, dl);
        check("bp_first_block_after", fb, 2);

        // Full throughput with downstream always ready.
        run_stream(12, 0, 1'b0, fb, dl);
        check("tput_never_blocked", fb, -1);

        // Random downstream backpressure.
        run_stream(16, 0, 1'b1, fb, dl);

        // Reset with two ops in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        drive_op(3'd0, 32'd5, 32'd0, 5'd1, 5'd21);
        @(negedge clk);
        drive_op(3'd1, 32'd64, 32'd0, 5'd2, 5'd22);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("flush_pre_out_valid", out_valid, 1);
        check("flush_rst_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_data", out_data, 0);
        check("flush_out_rd", out_rd, 0);
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_no_ghost_ops", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
